// File: rtl/data_path.sv
// Single-bus CPU datapath: register file, bus mux, 64-bit Z, ALU. Registers update one edge after their enable; Clear is async.
// No backpressure; optional MUL/DIV hardware enabled by defining DATAPATH_MULDIV_EN.
module data_path (
    input  logic        Clock,
    input  logic        Clear,
    input  logic        PCout,
    input  logic        ZHighout,
    input  logic        Zlowout,
    input  logic        MDRout,
    input  logic        R2out,
    input  logic        R3out,
    input  logic        R4out,
    input  logic        R5out,
    input  logic        R6out,
    input  logic        R7out,
    input  logic        MARin,
    input  logic        PCin,
    input  logic        MDRin,
    input  logic        IRin,
    input  logic        Yin,
    input  logic        IncPC,
    input  logic        Read,
    input  logic [4:0]  NEG,
    input  logic        R1in,
    input  logic        R2in,
    input  logic        R3in,
    input  logic        R4in,
    input  logic        R5in,
    input  logic        R6in,
    input  logic        R7in,
    input  logic        R8in,
    input  logic        R9in,
    input  logic        R10in,
    input  logic        R11in,
    input  logic        R12in,
    input  logic        R13in,
    input  logic        R14in,
    input  logic        R15in,
    input  logic        HIin,
    input  logic        LOin,
    input  logic        ZHighIn,
    input  logic        ZLowIn,
    input  logic        Cin,
    input  logic [31:0] Mdatain,
    output logic [31:0] BusMuxOut
);

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
`ifdef DATAPATH_MULDIV_EN
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
`endif

    // Slots 1..15 are R1..R15; the rest hold registers with no bus driver.
    localparam int MAR_IDX = 16;
    localparam int IR_IDX  = 17;
    localparam int HI_IDX  = 18;
    localparam int LO_IDX  = 19;

    logic [31:0] regs [1:19];
    logic [19:1] reg_ld;
    logic [31:0] pc;
    logic [31:0] mdr;
    logic [31:0] y;
    logic [63:0] z;
    logic [63:0] alu_res;

    assign reg_ld = {LOin, HIin, IRin, MARin,
                     R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                     R7in, R6in, R5in, R4in, R3in, R2in, R1in};

    always_comb begin
        if (PCout)         BusMuxOut = pc;
        else if (ZHighout) BusMuxOut = z[63:32];
        else if (Zlowout)  BusMuxOut = z[31:0];
        else if (MDRout)   BusMuxOut = mdr;
        else if (R2out)    BusMuxOut = regs[2];
        else if (R3out)    BusMuxOut = regs[3];
        else if (R4out)    BusMuxOut = regs[4];
        else if (R5out)    BusMuxOut = regs[5];
        else if (R6out)    BusMuxOut = regs[6];
        else if (R7out)    BusMuxOut = regs[7];
        else               BusMuxOut = '0;
    end

    logic [4:0]  sh_amt;
    logic        sh_big;
    logic [63:0] rot_r;
    logic [63:0] rot_l;
    logic [31:0] sra_v;

    assign sh_amt = BusMuxOut[4:0];
    assign sh_big = |BusMuxOut[31:5];
    assign rot_r  = {y, y} >> sh_amt;
    assign rot_l  = {y, y} << sh_amt;
    assign sra_v  = $unsigned($signed(y) >>> sh_amt);

`ifdef DATAPATH_MULDIV_EN
    logic signed [63:0] mul_p;
    logic        [31:0] div_q;
    logic        [31:0] div_r;

    assign mul_p = $signed({{32{y[31]}}, y}) * $signed({{32{BusMuxOut[31]}}, BusMuxOut});

    // Zero divisor and INT_MIN/-1 are resolved explicitly so the divider never sees them.
    always_comb begin
        div_q = '0;
        div_r = '0;
        if (BusMuxOut == 32'd0) begin
            div_q = 32'hFFFF_FFFF;
            div_r = y;
        end else if (y == 32'h8000_0000 && BusMuxOut == 32'hFFFF_FFFF) begin
            div_q = 32'h8000_0000;
            div_r = '0;
        end else begin
            div_q = $unsigned($signed(y) / $signed(BusMuxOut));
            div_r = $unsigned($signed(y) % $signed(BusMuxOut));
        end
    end
`endif

    always_comb begin
        alu_res = '0;
        case (NEG)
            OP_ADD:  alu_res[31:0] = y + BusMuxOut + {31'd0, Cin};
            OP_SUB:  alu_res[31:0] = y - BusMuxOut - {31'd0, Cin};
            OP_AND:  alu_res[31:0] = y & BusMuxOut;
            OP_OR:   alu_res[31:0] = y | BusMuxOut;
            OP_ROR:  alu_res[31:0] = rot_r[31:0];
            OP_ROL:  alu_res[31:0] = rot_l[63:32];
            OP_SHR:  alu_res[31:0] = sh_big ? 32'd0 : (y >> sh_amt);
            OP_SHRA: alu_res[31:0] = sh_big ? {32{y[31]}} : sra_v;
            OP_SHL:  alu_res[31:0] = sh_big ? 32'd0 : (y << sh_amt);
            OP_NEG:  alu_res[31:0] = 32'd0 - BusMuxOut;
            OP_NOT:  alu_res[31:0] = ~BusMuxOut;
`ifdef DATAPATH_MULDIV_EN
            OP_MUL:  alu_res = $unsigned(mul_p);
            OP_DIV:  alu_res = {div_r, div_q};
`endif
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            for (int i = 1; i <= 19; i++) regs[i] <= '0;
            pc  <= '0;
            mdr <= '0;
            y   <= '0;
            z   <= '0;
        end else begin
            for (int i = 1; i <= 19; i++)
                if (reg_ld[i]) regs[i] <= BusMuxOut;
            if (IncPC)     pc  <= pc + 32'd1;
            else if (PCin) pc  <= BusMuxOut;
            if (MDRin)     mdr <= Read ? Mdatain : BusMuxOut;
            if (Yin)       y   <= BusMuxOut;
            if (ZHighIn)   z[63:32] <= alu_res[63:32];
            if (ZLowIn)    z[31:0]  <= alu_res[31:0];
        end
    end

endmodule

// File: tb/tb_data_path.sv
// Directed bench for data_path: register loads, bus priority, ALU corners, PC increment, async clear.
module tb_data_path;

    logic        Clock = 1'b0;
    logic        Clear;
    logic        PCout, ZHighout, Zlowout, MDRout;
    logic [7:2]  rout;
    logic        MARin, PCin, MDRin, IRin, Yin, IncPC, Read;
    logic [4:0]  NEG;
    logic [15:1] rin;
    logic        HIin, LOin, ZHighIn, ZLowIn, Cin;
    logic [31:0] Mdatain;
    logic [31:0] BusMuxOut;

    int tests  = 0;
    int failed = 0;

    always #5 Clock = ~Clock;

    data_path dut (
        .Clock(Clock), .Clear(Clear),
        .PCout(PCout), .ZHighout(ZHighout), .Zlowout(Zlowout), .MDRout(MDRout),
        .R2out(rout[2]), .R3out(rout[3]), .R4out(rout[4]), .R5out(rout[5]),
        .R6out(rout[6]), .R7out(rout[7]),
        .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
        .IncPC(IncPC), .Read(Read), .NEG(NEG),
        .R1in(rin[1]), .R2in(rin[2]), .R3in(rin[3]), .R4in(rin[4]), .R5in(rin[5]),
        .R6in(rin[6]), .R7in(rin[7]), .R8in(rin[8]), .R9in(rin[9]), .R10in(rin[10]),
        .R11in(rin[11]), .R12in(rin[12]), .R13in(rin[13]), .R14in(rin[14]), .R15in(rin[15]),
        .HIin(HIin), .LOin(LOin), .ZHighIn(ZHighIn), .ZLowIn(ZLowIn), .Cin(Cin),
        .Mdatain(Mdatain), .BusMuxOut(BusMuxOut)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic idle();
        {PCout, ZHighout, Zlowout, MDRout} = '0;
        rout = '0; rin = '0;
        {MARin, PCin, MDRin, IRin, Yin, IncPC, Read} = '0;
        {HIin, LOin, ZHighIn, ZLowIn, Cin} = '0;
        NEG = '0;
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
        idle();
    endtask

    // sel: 0 PC, 1 ZHigh, 2 ZLow, 3 MDR, 4..9 R2..R7
    task automatic peek(input int sel, output logic [31:0] v);
        case (sel)
            0: PCout = 1'b1;
            1: ZHighout = 1'b1;
            2: Zlowout = 1'b1;
            3: MDRout = 1'b1;
            default: rout[sel - 2] = 1'b1;
        endcase
        #1;
        v = BusMuxOut;
        idle();
    endtask

    task automatic load_mdr(input logic [31:0] v);
        Mdatain = v; Read = 1'b1; MDRin = 1'b1;
        tick();
    endtask

    task automatic load_reg(input int k, input logic [31:0] v);
        load_mdr(v);
        MDRout = 1'b1; rin[k] = 1'b1;
        tick();
    endtask

    task automatic run_alu(input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] op, input logic c);
        load_mdr(a);
        MDRout = 1'b1; Yin = 1'b1;
        tick();
        load_mdr(b);
        MDRout = 1'b1; NEG = op; Cin = c; ZHighIn = 1'b1; ZLowIn = 1'b1;
        tick();
    endtask

    task automatic alu_chk(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] op, input logic c,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        logic [31:0] v;
        run_alu(a, b, op, c);
        peek(2, v); check({tag, "_lo"}, v, exp_lo);
        peek(1, v); check({tag, "_hi"}, v, exp_hi);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] v;
        idle();
        Mdatain = '0;
        Clear = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        #1 check("reset_bus_none", BusMuxOut, 32'h0);
        Clear = 1'b1;
        peek(0, v); check("reset_pc", v, 32'h0);
        peek(2, v); check("reset_zlo", v, 32'h0);
        peek(3, v); check("reset_mdr", v, 32'h0);

        load_reg(7, 32'h12);
        load_reg(3, 32'h14);
        load_reg(6, 32'h18);
        peek(9, v); check("r7_load", v, 32'h12);
        peek(5, v); check("r3_load", v, 32'h14);
        peek(8, v); check("r6_load", v, 32'h18);

        rout[3] = 1'b1; rout[7] = 1'b1; #1;
        check("prio_r3_over_r7", BusMuxOut, 32'h14);
        MDRout = 1'b1; #1;
        check("prio_mdr_over_r3", BusMuxOut, 32'h18);
        idle();

        // MDR from bus when Read is low
        rout[3] = 1'b1; MDRin = 1'b1;
        tick();
        peek(3, v); check("mdr_from_bus", v, 32'h14);

        rout[2] = 1'b1; Yin = 1'b1;
        tick();
        rout[3] = 1'b1; NEG = 5'b10001; ZLowIn = 1'b1;
        tick();
        Zlowout = 1'b1; rin[6] = 1'b1;
        tick();
        peek(8, v); check("neg_r6", v, 32'hFFFF_FFEC);

        load_mdr(32'h7);
        MDRout = 1'b1; PCin = 1'b1;
        tick();
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1;
        tick();
        check("mar_from_pc", dut.regs[16], 32'h7);
        peek(0, v); check("pc_inc", v, 32'h8);
        MDRout = 1'b1; PCin = 1'b1; IncPC = 1'b1;
        tick();
        peek(0, v); check("incpc_over_pcin", v, 32'h9);

        alu_chk("add_wrap", 32'hFFFF_FFFF, 32'h1,        5'b00011, 1'b0, 32'h0, 32'h0);
        alu_chk("add_cin",  32'h5,         32'h6,        5'b00011, 1'b1, 32'h0, 32'hC);
        alu_chk("sub_cin",  32'hA,         32'h3,        5'b00100, 1'b1, 32'h0, 32'h6);
        alu_chk("and",      32'hF0F0_FF00, 32'h0FF0_F0F0, 5'b00101, 1'b0, 32'h0, 32'h00F0_F000);
        alu_chk("or",       32'hF000_000F, 32'h0000_FF00, 5'b00110, 1'b0, 32'h0, 32'hF000_FF0F);
        alu_chk("ror8",     32'h1234_5678, 32'h8,        5'b00111, 1'b0, 32'h0, 32'h7812_3456);
        alu_chk("rol4",     32'h1234_5678, 32'h4,        5'b01000, 1'b0, 32'h0, 32'h2345_6781);
        alu_chk("shr31",    32'h8000_0000, 32'd31,       5'b01001, 1'b0, 32'h0, 32'h1);
        alu_chk("shra4",    32'h8000_0000, 32'h4,        5'b01010, 1'b0, 32'h0, 32'hF800_0000);
        alu_chk("shra40",   32'h8000_0000, 32'd40,       5'b01010, 1'b0, 32'h0, 32'hFFFF_FFFF);
        alu_chk("shl33",    32'h0000_0001, 32'd33,       5'b01011, 1'b0, 32'h0, 32'h0);
        alu_chk("shl3",     32'h0000_0001, 32'd3,        5'b01011, 1'b0, 32'h0, 32'h8);
        alu_chk("not",      32'h0,         32'h0F0F_0000, 5'b10010, 1'b0, 32'h0, 32'hF0F0_FFFF);
        alu_chk("bad_op",   32'h5,         32'h6,        5'b00000, 1'b0, 32'h0, 32'h0);
`ifdef DATAPATH_MULDIV_EN
        alu_chk("mul",      32'hFFFF_FFFD, 32'h5,        5'b01111, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        alu_chk("div",      32'h14,        32'h6,        5'b10000, 1'b0, 32'h2, 32'h3);
        alu_chk("div_neg",  32'hFFFF_FFEC, 32'h6,        5'b10000, 1'b0, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
        alu_chk("div_zero", 32'h1234,      32'h0,        5'b10000, 1'b0, 32'h1234, 32'hFFFF_FFFF);
`else
        alu_chk("mul_off",  32'hFFFF_FFFD, 32'h5,        5'b01111, 1'b0, 32'h0, 32'h0);
        alu_chk("div_off",  32'h14,        32'h6,        5'b10000, 1'b0, 32'h0, 32'h0);
`endif

        // Async clear between edges, then clear held through an edge
        load_reg(6, 32'h18);
        run_alu(32'h1, 32'h2, 5'b00011, 1'b0);
        @(negedge Clock);
        Clear = 1'b0;
        #1 check("clr_bus_none", BusMuxOut, 32'h0);
        rout[6] = 1'b1; #1 check("clr_r6", BusMuxOut, 32'h0);
        idle();
        Zlowout = 1'b1; #1 check("clr_zlo", BusMuxOut, 32'h0);
        idle();
        ZHighout = 1'b1; #1 check("clr_zhi", BusMuxOut, 32'h0);
        idle();
        Mdatain = 32'h55; Read = 1'b1; MDRin = 1'b1;
        @(posedge Clock); #1;
        MDRout = 1'b1; #1 check("clr_overrides_load", BusMuxOut, 32'h0);
        idle();
        Clear = 1'b1;
        load_mdr(32'h55);
        peek(3, v); check("load_after_clear", v, 32'h55);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
